// File: rtl/uart_frame_generator.sv
// uart_frame_generator
// Serialises one byte per frame onto a UART line (start, 8 data bits LSB
// first, optional parity, stop). Line configuration is taken from two
// registers written through snooped APB traffic. Each frame uses the
// configuration that was current when its byte was accepted.

module uart_frame_generator #(
  parameter logic [4:0] SE_ADDR = 5'h04,
  parameter logic [4:0] BR_ADDR = 5'h08
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic        inj_par_err,
  input  logic        inj_stop_err,
  output logic        uart_net,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  state_t      state_next;

  logic [2:0]  se_reg;
  logic [7:0]  br_reg;

  logic [7:0]  data_lat;
  logic [7:0]  br_lat;
  logic        par_en_lat;
  logic        par_odd_lat;
  logic        par_err_lat;
  logic        stop_err_lat;

  logic [11:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  idx_next;
  logic [11:0] bit_last;
  logic        bit_end;
  logic        cfg_wr;
  logic        accept;
  logic        par_bit;
  logic        net_next;
  logic        unused_bits;

  // Only full-word writes count as configuration writes; only paddr[4:0] is decoded.
  assign cfg_wr      = psel & penable & pwrite & (&pstrb);
  assign accept      = tx_valid & tx_ready;
  // Bit time is 16*(br+1) cycles, so its last count is {br, 4'hF}.
  assign bit_last    = {br_lat, 4'hF};
  assign bit_end     = (bit_cnt == bit_last);
  assign par_bit     = (^data_lat) ^ par_odd_lat ^ par_err_lat;
  assign unused_bits = &{1'b0, paddr[31:5], pwdata[31:8], se_reg[0]};

  // Configuration registers, updated immediately on a qualifying APB write.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      se_reg <= 3'b000;
      br_reg <= 8'h00;
    end else if (cfg_wr) begin
      if (paddr[4:0] == SE_ADDR) se_reg <= pwdata[2:0];
      if (paddr[4:0] == BR_ADDR) br_reg <= pwdata[7:0];
    end
  end

  // Snapshot of byte, configuration and error injects, frozen for the whole frame.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      data_lat     <= 8'h00;
      br_lat       <= 8'h00;
      par_en_lat   <= 1'b0;
      par_odd_lat  <= 1'b0;
      par_err_lat  <= 1'b0;
      stop_err_lat <= 1'b0;
    end else if (accept) begin
      data_lat     <= tx_data;
      br_lat       <= br_reg;
      par_en_lat   <= se_reg[1];
      par_odd_lat  <= se_reg[2];
      par_err_lat  <= inj_par_err;
      stop_err_lat <= inj_stop_err;
    end
  end

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_next;
  end

  // Bit-time counter and data-bit index; both sit at zero while idle.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      bit_cnt <= 12'd0;
      bit_idx <= 3'd0;
    end else if (state == IDLE) begin
      bit_cnt <= 12'd0;
      bit_idx <= 3'd0;
    end else if (bit_end) begin
      bit_cnt <= 12'd0;
      if (state == DATA) bit_idx <= bit_idx + 3'd1;
    end else begin
      bit_cnt <= bit_cnt + 12'd1;
    end
  end

  // Next-state logic: each non-idle state lasts whole bit times.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_next = par_en_lat ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; the line level is computed from the next state so it can be registered.
  always_comb begin
    tx_ready   = (state == IDLE);
    busy       = (state != IDLE);
    frame_done = (state == STOP) && bit_end;
    idx_next   = ((state == DATA) && bit_end) ? bit_idx + 3'd1 : bit_idx;
    net_next   = 1'b1;
    unique case (state_next)
      IDLE:    net_next = 1'b1;
      START:   net_next = 1'b0;
      DATA:    net_next = data_lat[idx_next];
      PARITY:  net_next = par_bit;
      STOP:    net_next = ~stop_err_lat;
      default: net_next = 1'b1;
    endcase
  end

  // Registered serial line; reset forces it high at once, aborting any frame.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) uart_net <= 1'b1;
    else        uart_net <= net_next;
  end

endmodule

// File: tb/tb_uart_frame_generator.sv
// tb_uart_frame_generator
// Scoreboard bench: each accepted byte pushes its expected bit pattern and
// bit time; a line monitor pops it when a start bit appears and checks every
// bit cycle by cycle, plus frame_done, busy and tx_ready over the frame.

module tb_uart_frame_generator;

  localparam logic [4:0] SE = 5'h04;
  localparam logic [4:0] BR = 5'h08;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
    int          bt;
  } frame_t;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        inj_par_err;
  logic        inj_stop_err;
  logic        uart_net;
  logic        busy;
  logic        frame_done;

  frame_t      exp_q[$];
  logic [2:0]  se_m;
  int          br_m;
  int          vectors;
  int          miscompares;
  int          last_idle;

  uart_frame_generator dut (
    .pclk         (pclk),
    .preset       (preset),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .inj_par_err  (inj_par_err),
    .inj_stop_err (inj_stop_err),
    .uart_net     (uart_net),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // 10 ns clock.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Hard stop in case the DUT never produces an expected event.
  initial begin
    #(10 * 95000);
    $display("[TB] FAIL watchdog: got more than 95000 cycles, expected fewer");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic apbWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4000_0000 | {27'h0, addr}; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (&strb) begin
      if (addr == SE) se_m = data[2:0];
      if (addr == BR) br_m = int'(data[7:0]);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic perr, input logic serr, input bit hold);
    frame_t f;
    logic   pb;
    int     waited;
    waited = 0;
    @(posedge pclk); #1;
    tx_data = data; tx_valid = 1'b1; inj_par_err = perr; inj_stop_err = serr;
    @(negedge pclk);
    while (tx_ready !== 1'b1 && waited < 50000) begin
      @(negedge pclk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    f.bt    = 16 * (br_m + 1);
    f.bits  = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = data[i];
    pb = (^data) ^ se_m[2] ^ perr;
    if (se_m[1]) begin
      f.bits[9]  = pb;
      f.bits[10] = ~serr;
      f.nbits    = 11;
    end else begin
      f.bits[9]  = ~serr;
      f.nbits    = 10;
    end
    exp_q.push_back(f);
    @(posedge pclk); #1;
    if (!hold) tx_valid = 1'b0;
    inj_par_err = 1'b0; inj_stop_err = 1'b0;
  endtask

  task automatic monitorFrame();
    frame_t e;
    int idle, match, done_cnt, done_at, ready_cnt, busy_cnt, cyc;
    idle = 0;
    @(negedge pclk);
    while (uart_net !== 1'b0 && idle < 50000) begin
      idle++;
      @(negedge pclk);
    end
    last_idle = idle;
    if (uart_net !== 1'b0) begin
      checkOutput("start_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    done_cnt = 0; done_at = 0; ready_cnt = 0; busy_cnt = 0; cyc = 0;
    for (int k = 0; k < e.nbits; k++) begin
      match = 0;
      for (int c = 0; c < e.bt; c++) begin
        if (cyc != 0) @(negedge pclk);
        cyc++;
        if (uart_net === e.bits[k]) match++;
        if (frame_done === 1'b1) begin
          done_cnt++;
          if (done_at == 0) done_at = cyc;
        end
        if (tx_ready === 1'b1) ready_cnt++;
        if (busy === 1'b1) busy_cnt++;
      end
      checkOutput($sformatf("bit%0d_cycles", k), match, e.bt);
    end
    checkOutput("frame_done_cycle", done_at, e.nbits * e.bt);
    checkOutput("frame_done_count", done_cnt, 1);
    checkOutput("tx_ready_during_frame", ready_cnt, 0);
    checkOutput("busy_cycles", busy_cnt, e.nbits * e.bt);
  endtask

  initial begin
    int hi_cnt, done_cnt;
    vectors = 0; miscompares = 0; last_idle = 0;
    se_m = 3'b000; br_m = 0;
    preset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    tx_valid = 1'b0; tx_data = '0; inj_par_err = 1'b0; inj_stop_err = 1'b0;

    // Reset values.
    repeat (3) @(posedge pclk);
    #2;
    checkOutput("reset_uart_net", uart_net, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("post_reset_tx_ready", tx_ready, 1);
    checkOutput("post_reset_uart_net", uart_net, 1);

    // Partial-strobe write must be ignored; 0x55, 16 cycles/bit, no parity.
    $display("[TB] frame 0x55, br=0, no parity");
    apbWrite(BR, 32'h0000_0005, 4'b0111);
    apbWrite(SE, 32'h0000_0000, 4'hF);
    fork
      monitorFrame();
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    join
    @(negedge pclk);
    checkOutput("idle_after_55", uart_net, 1);

    // Even parity, 48 cycles/bit.
    $display("[TB] frame 0x07, br=2, even parity");
    apbWrite(SE, 32'h0000_0002, 4'hF);
    apbWrite(BR, 32'h0000_0002, 4'hF);
    fork
      monitorFrame();
      applyStimulus(8'h07, 1'b0, 1'b0, 1'b0);
    join
    @(negedge pclk);
    checkOutput("idle_after_07", uart_net, 1);

    // Odd parity with parity inject, then a frame with stop inject.
    $display("[TB] odd parity with error injects");
    apbWrite(SE, 32'h0000_0006, 4'hF);
    apbWrite(BR, 32'h0000_0000, 4'hF);
    fork
      begin
        monitorFrame();
        monitorFrame();
      end
      begin
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b0, 1'b1, 1'b0);
      end
    join
    @(negedge pclk);
    checkOutput("idle_after_stop_err", uart_net, 1);

    // Baud change mid-frame affects only the next frame.
    $display("[TB] baud write mid-frame");
    apbWrite(SE, 32'h0000_0000, 4'hF);
    fork
      begin
        monitorFrame();
        monitorFrame();
      end
      begin
        applyStimulus(8'h3A, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge pclk);
        apbWrite(BR, 32'h0000_00FF, 4'hF);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0);
      end
    join
    @(negedge pclk);
    checkOutput("idle_after_slow", uart_net, 1);
    apbWrite(BR, 32'h0000_0000, 4'hF);

    // tx_valid held high across two frames: exactly one idle cycle between them.
    $display("[TB] back-to-back frames");
    fork
      begin
        monitorFrame();
        monitorFrame();
        checkOutput("idle_gap_cycles", last_idle, 1);
      end
      begin
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
      end
    join
    @(negedge pclk);
    checkOutput("idle_after_pair", uart_net, 1);

    // Reset during DATA bit 3 aborts the frame with no frame_done.
    $display("[TB] reset mid-frame");
    applyStimulus(8'h96, 1'b0, 1'b0, 1'b0);
    repeat (70) @(posedge pclk);
    #3;
    preset = 1'b1;
    #1;
    checkOutput("abort_uart_net", uart_net, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_frame_done", frame_done, 0);
    exp_q.delete();
    se_m = 3'b000; br_m = 0;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    hi_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (uart_net === 1'b1) hi_cnt++;
      if (frame_done === 1'b1) done_cnt++;
    end
    checkOutput("abort_line_idle", hi_cnt, 50);
    checkOutput("abort_no_done", done_cnt, 0);
    fork
      monitorFrame();
      applyStimulus(8'h96, 1'b0, 1'b0, 1'b0);
    join
    @(negedge pclk);
    checkOutput("idle_after_recovery", uart_net, 1);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
